// File: rtl/des_subkey_sequencer_if.sv
// Key-schedule request and subkey stream bundle; master is the sequencer, slave is the
// key register plus round core side that requests schedules and consumes subkeys.
interface des_subkey_sequencer_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        busy;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] sk;
  logic [3:0]  sk_round;
  logic        done;

  modport master (
    input  start, decrypt, key, sk_ready,
    output busy, sk_valid, sk, sk_round, done
  );

  modport slave (
    output start, decrypt, key, sk_ready,
    input  busy, sk_valid, sk, sk_round, done
  );
endinterface

// File: rtl/des_subkey_sequencer.sv
// DES key schedule issuing 16 PC-2 subkeys one per valid/ready transfer, first valid the
// cycle after start; C/D rotate left (encrypt, K1..K16) or right (decrypt, K16..K1) only on transfer.
module des_subkey_sequencer (
  input  logic                          clk,
  input  logic                          rst,
  des_subkey_sequencer_if.master        bus
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Entries of the 1-based shift table that are 1 (positions 1, 2, 9, 16); all others are 2.
  localparam logic [16:1] SHIFT_ONE = 16'b1000_0001_0000_0011;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int j = 0; j < 56; j++) r[55-j] = k[64-PC1[j]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [3:0]  n_q, n_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        done_q, done_d;

  logic [55:0] key_pc1;
  logic [4:0]  shift_idx;
  logic        shift_two;
  logic        xfer;

  assign key_pc1 = pc1(bus.key);
  assign xfer    = (state_q == ISSUE) && bus.sk_ready;

  always_comb begin
    shift_idx = 5'd1;
    if (n_q != 4'd15) shift_idx = mode_q ? (5'd16 - {1'b0, n_q}) : ({1'b0, n_q} + 5'd2);
  end
  assign shift_two = ~SHIFT_ONE[shift_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      n_q     <= 4'd0;
      c_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      c_q     <= c_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    c_d     = c_q;
    d_d     = d_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          mode_d  = bus.decrypt;
          n_d     = 4'd0;
          // PC-1(key) is already C16/D16, so decrypt starts unrotated.
          if (bus.decrypt) begin
            c_d = key_pc1[55:28];
            d_d = key_pc1[27:0];
          end else begin
            c_d = rotl(key_pc1[55:28], 1'b0);
            d_d = rotl(key_pc1[27:0], 1'b0);
          end
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (n_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            n_d = n_q + 4'd1;
            c_d = mode_q ? rotr(c_q, shift_two) : rotl(c_q, shift_two);
            d_d = mode_q ? rotr(d_q, shift_two) : rotl(d_q, shift_two);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == ISSUE);
    bus.sk_valid = (state_q == ISSUE);
    bus.sk_round = mode_q ? (4'd15 - n_q) : n_q;
    bus.sk       = pc2({c_q, d_q});
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_des_subkey_sequencer.sv
// Bench for des_subkey_sequencer: known-answer vectors plus a table-driven key schedule model
// that rotates C0/D0 by the cumulative shift count for each round.
module tb_des_subkey_sequencer;

  logic clk;
  logic rst;
  des_subkey_sequencer_if bus ();

  des_subkey_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int TPC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TPC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B  = 64'h123456789ABCDEF0;
  localparam logic [63:0] PARITY = 64'h0101010101010101;
  localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

  int errors = 0;
  int checks = 0;

  logic [47:0] exp_ks [16];
  logic [47:0] got_ks [16];
  logic [3:0]  got_rd [16];
  int got_n, busy_cyc, cyc, stall_err, done_early;
  bit timed_out;

  // Subkeys in K1..K16 order; round r uses C0/D0 rotated left by the sum of the first r+1 shifts.
  task automatic build_model(input logic [63:0] key);
    bit kb [65];
    bit c0 [28];
    bit d0 [28];
    bit cd [56];
    int cum;
    for (int i = 1; i <= 64; i++) kb[i] = key[64-i];
    kb[0] = 1'b0;
    for (int j = 0; j < 28; j++) begin
      c0[j] = kb[TPC1[j]];
      d0[j] = kb[TPC1[28+j]];
    end
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum += SHIFTS[r];
      for (int j = 0; j < 28; j++) begin
        cd[j]    = c0[(j + cum) % 28];
        cd[28+j] = d0[(j + cum) % 28];
      end
      for (int j = 0; j < 48; j++) exp_ks[r][47-j] = cd[TPC2[j]-1];
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accepting edge.
  task automatic start_req(input logic [63:0] k, input bit dec);
    bus.key     = k;
    bus.decrypt = dec;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.key     = {$urandom, $urandom};
    bus.decrypt = 1'($urandom_range(0, 1));
  endtask

  // Drives sk_ready and records transfers until 16 are seen; returns at the negedge after the last.
  task automatic collect(input bit rnd_ready, input int inject_at, input logic [63:0] inj_key);
    logic [47:0] ps;
    logic [3:0]  pr;
    bit pstall;
    bit rdy;
    int burst;
    got_n = 0; busy_cyc = 0; cyc = 0; stall_err = 0; done_early = 0; timed_out = 0;
    pstall = 0; burst = 0; ps = '0; pr = '0;
    while (got_n < 16) begin
      if (cyc >= 400) begin
        timed_out = 1;
        break;
      end
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) done_early++;
      if (pstall && (!bus.sk_valid || bus.sk !== ps || bus.sk_round !== pr)) stall_err++;
      if (!rnd_ready) rdy = 1'b1;
      else if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else if ($urandom_range(0, 5) == 0) begin
        rdy = 1'b0;
        burst = 4;
      end else rdy = 1'($urandom_range(0, 1));
      bus.sk_ready = rdy;
      if (got_n == inject_at && bus.sk_valid) begin
        bus.start   = 1'b1;
        bus.key     = inj_key;
        bus.decrypt = 1'b1;
      end else bus.start = 1'b0;
      if (bus.sk_valid && rdy) begin
        got_ks[got_n] = bus.sk;
        got_rd[got_n] = bus.sk_round;
        got_n++;
      end
      pstall = bus.sk_valid && !rdy;
      ps = bus.sk;
      pr = bus.sk_round;
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.sk_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b1; bus.decrypt = 1'b0; bus.key = KEY_A; bus.sk_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.sk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.sk_valid); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.sk_round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d want 0", bus.sk_round); end
    checks++; if (bus.sk !== 48'h0) begin errors++; $display("FAIL reset_sk: got %h want 0", bus.sk); end
    rst = 1'b0; bus.start = 1'b0; bus.sk_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy %b want 0", bus.busy); end
  endtask

  task automatic test_encrypt_kat;
    build_model(KEY_A);
    start_req(KEY_A, 1'b0);
    collect(1'b0, -1, '0);
    checks++; if (timed_out) begin errors++; $display("FAIL enc_timeout: got %0d transfers want 16", got_n); end
    checks++; if (got_ks[0] !== K1_A) begin errors++; $display("FAIL enc_k1: got %h want %h", got_ks[0], K1_A); end
    checks++; if (got_rd[0] !== 4'd0) begin errors++; $display("FAIL enc_k1_round: got %0d want 0", got_rd[0]); end
    checks++; if (got_ks[1] !== K2_A) begin errors++; $display("FAIL enc_k2: got %h want %h", got_ks[1], K2_A); end
    checks++; if (got_ks[15] !== K16_A) begin errors++; $display("FAIL enc_k16: got %h want %h", got_ks[15], K16_A); end
    checks++; if (got_rd[15] !== 4'd15) begin errors++; $display("FAIL enc_k16_round: got %0d want 15", got_rd[15]); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_ks[i] !== exp_ks[i] || got_rd[i] !== 4'(i)) begin
        errors++; $display("FAIL enc_model[%0d]: got %h/%0d want %h/%0d", i, got_ks[i], got_rd[i], exp_ks[i], i);
      end
    end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL enc_cycles: got %0d want 16", cyc); end
    checks++; if (busy_cyc !== 16 || bus.busy !== 1'b0) begin errors++; $display("FAIL enc_busy: got %0d cycles, now %b want 16, 0", busy_cyc, bus.busy); end
    checks++; if (bus.done !== 1'b1 || bus.sk_valid !== 1'b0) begin errors++; $display("FAIL enc_done: got done %b valid %b want 1 0", bus.done, bus.sk_valid); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL enc_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_decrypt;
    build_model(KEY_A);
    start_req(KEY_A, 1'b1);
    collect(1'b0, -1, '0);
    checks++; if (timed_out) begin errors++; $display("FAIL dec_timeout: got %0d transfers want 16", got_n); end
    checks++; if (got_ks[0] !== K16_A || got_rd[0] !== 4'd15) begin errors++; $display("FAIL dec_first: got %h/%0d want %h/15", got_ks[0], got_rd[0], K16_A); end
    checks++; if (got_ks[15] !== K1_A || got_rd[15] !== 4'd0) begin errors++; $display("FAIL dec_last: got %h/%0d want %h/0", got_ks[15], got_rd[15], K1_A); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_ks[i] !== exp_ks[15-i] || got_rd[i] !== 4'(15 - i)) begin
        errors++; $display("FAIL dec_model[%0d]: got %h/%0d want %h/%0d", i, got_ks[i], got_rd[i], exp_ks[15-i], 15 - i);
      end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL dec_done: got %b want 1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [63:0] k;
    for (int it = 0; it < 3; it++) begin
      k = (it == 0) ? KEY_A : {$urandom, $urandom};
      build_model(k);
      start_req(k, 1'b0);
      collect(1'b1, -1, '0);
      checks++; if (timed_out || got_n !== 16) begin errors++; $display("FAIL bp_count[%0d]: got %0d transfers want 16", it, got_n); end
      checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable[%0d]: got %0d changes while stalled want 0", it, stall_err); end
      checks++; if (done_early !== 0) begin errors++; $display("FAIL bp_early_done[%0d]: got %0d want 0", it, done_early); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (got_ks[i] !== exp_ks[i] || got_rd[i] !== 4'(i)) begin
          errors++; $display("FAIL bp_order[%0d][%0d]: got %h/%0d want %h/%0d", it, i, got_ks[i], got_rd[i], exp_ks[i], i);
        end
      end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bp_done[%0d]: got %b want 1", it, bus.done); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy;
    build_model(KEY_B);
    start_req(KEY_B, 1'b0);
    collect(1'b0, 7, KEY_A ^ 64'hFFFF_0000_FFFF_0000);
    checks++; if (timed_out) begin errors++; $display("FAIL swb_timeout: got %0d transfers want 16", got_n); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_ks[i] !== exp_ks[i] || got_rd[i] !== 4'(i)) begin
        errors++; $display("FAIL swb_seq[%0d]: got %h/%0d want %h/%0d", i, got_ks[i], got_rd[i], exp_ks[i], i);
      end
    end
    checks++; if (done_early !== 0 || bus.done !== 1'b1) begin errors++; $display("FAIL swb_done: got early %0d final %b want 0 1", done_early, bus.done); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL swb_after: got done %b busy %b want 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_reset_mid_run;
    logic [63:0] k;
    bit hit;
    int dcount;
    hit = 0;
    start_req({$urandom, $urandom}, 1'b0);
    bus.sk_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.sk_valid && bus.sk_round == 4'd9) begin
        rst = 1'b1;
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmr_reach9: got no round 9 want round 9 within 40 cycles"); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.sk_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL rmr_abort: got busy %b valid %b done %b want 0 0 0", bus.busy, bus.sk_valid, bus.done);
    end
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL rmr_no_done: got %0d pulses want 0", dcount); end
    k = {$urandom, $urandom};
    build_model(k);
    start_req(k, 1'b0);
    collect(1'b0, -1, '0);
    checks++; if (got_ks[0] !== exp_ks[0] || got_rd[0] !== 4'd0) begin errors++; $display("FAIL rmr_new_k1: got %h/%0d want %h/0", got_ks[0], got_rd[0], exp_ks[0]); end
    checks++; if (timed_out || got_ks[15] !== exp_ks[15]) begin errors++; $display("FAIL rmr_new_k16: got %h want %h", got_ks[15], exp_ks[15]); end
    @(negedge clk);
  endtask

  task automatic test_parity_back_to_back;
    build_model(KEY_A);
    start_req(KEY_A ^ PARITY, 1'b0);
    collect(1'b0, -1, '0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_ks[i] !== exp_ks[i]) begin errors++; $display("FAIL par_a[%0d]: got %h want %h", i, got_ks[i], exp_ks[i]); end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.done); end
    build_model(KEY_B);
    start_req(KEY_B ^ PARITY, 1'b1);
    checks++; if (bus.sk_valid !== 1'b1 || bus.sk !== exp_ks[15]) begin
      errors++; $display("FAIL b2b_first_valid: got valid %b sk %h want 1 %h", bus.sk_valid, bus.sk, exp_ks[15]);
    end
    collect(1'b0, -1, '0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got_ks[i] !== exp_ks[15-i] || got_rd[i] !== 4'(15 - i)) begin
        errors++; $display("FAIL par_b[%0d]: got %h/%0d want %h/%0d", i, got_ks[i], got_rd[i], exp_ks[15-i], 15 - i);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_encrypt_kat;
    test_decrypt;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_run;
    test_parity_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
